// File: rtl/ssd_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// segment bit order, hex-to-segment table and scan FSM states.
package ssd_pkg;

  // Segment vector is {g,f,e,d,c,b,a}: a is bit 0, g is bit 6.
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  typedef logic [SEG_G:SEG_A] seg_t;

  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    BLANK,
    SHOW
  } state_e;

endpackage

// File: rtl/ssd_scan_mux_if.sv
// Value-producer / display-pin bundle for ssd_scan_mux.
interface ssd_scan_mux_if #(
  parameter int DIGITS = 2
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   blank_mask;
  logic                lz_suppress;
  logic [6:0]          ssd;
  logic [DIGITS-1:0]   dsel;
  logic                ssdcat;

  modport master (
    output value, load, blank_mask, lz_suppress,
    input  ssd, dsel, ssdcat
  );

  modport slave (
    input  value, load, blank_mask, lz_suppress,
    output ssd, dsel, ssdcat
  );
endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-high segments, forced off when dark.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dark_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = '0;
    if (!dark_i) seg_o = SEG_LUT[nibble_i];
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// N-digit multiplexed 7-segment driver: per-slot blank/show scan with a
// shadow value register, per-digit blanking and leading-zero suppression.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst,
  ssd_scan_mux_if.slave bus
);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("ssd_scan_mux: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("ssd_scan_mux: DIGITS must be in 1..8");
  end

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_BLANK_END = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST      = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);
  localparam seg_t          SEG_OFF       = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_e              state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]          nib_q, nib_d;
  logic                dark_q, dark_d;
  seg_t                ssd_q, ssd_d;
  logic [DIGITS-1:0]   dsel_q, dsel_d;
  logic                cat_q, cat_d;

  logic [3:0] cur_nib;
  logic       cur_mask;
  logic       upper_nz;
  seg_t       dec_seg;

  ssd_hex_decoder u_dec (
    .nibble_i (nib_q),
    .dark_i   (dark_q),
    .seg_o    (dec_seg)
  );

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q + 1'b1;
    idx_d    = idx_q;
    nib_d    = nib_q;
    dark_d   = dark_q;
    shadow_d = bus.load ? bus.value : shadow_q;
    cur_nib  = '0;
    cur_mask = 1'b0;
    upper_nz = 1'b0;

    // upper_nz: any nonzero nibble at or above the current digit
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = shadow_q[4*i +: 4];
        cur_mask = bus.blank_mask[i];
      end
      if (IW'(i) >= idx_q && shadow_q[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end

    case (state_q)
      BLANK: begin
        if (pre_q == PRE_BLANK_END) begin
          state_d = SHOW;
          nib_d   = cur_nib;
          dark_d  = cur_mask | (bus.lz_suppress && idx_q != '0 && !upper_nz);
        end
      end
      SHOW: begin
        if (pre_q == PRE_LAST) begin
          state_d = BLANK;
          pre_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase

    ssd_d  = SEG_OFF;
    dsel_d = '0;
    cat_d  = idx_q[0];
    if (state_q == SHOW) begin
      ssd_d = dec_seg ^ SEG_OFF;
      for (int unsigned i = 0; i < DIGITS; i++) dsel_d[i] = (idx_q == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BLANK;
      pre_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      nib_q    <= '0;
      dark_q   <= 1'b0;
      ssd_q    <= SEG_OFF;
      dsel_q   <= '0;
      cat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      nib_q    <= nib_d;
      dark_q   <= dark_d;
      ssd_q    <= ssd_d;
      dsel_q   <= dsel_d;
      cat_q    <= cat_d;
    end
  end

  assign bus.ssd    = ssd_q;
  assign bus.dsel   = dsel_q;
  assign bus.ssdcat = cat_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux: vector table, directed corner
// sequences and a slot/phase reference model driven by random stimulus.
module tb_ssd_scan_mux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_mux_if #(.DIGITS(4)) m_if ();
  ssd_scan_mux_if #(.DIGITS(4)) a_if ();
  ssd_scan_mux_if #(.DIGITS(2)) t_if ();

  ssd_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0))
    u_main (.clk(clk), .rst(rst), .bus(m_if));
  ssd_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1))
    u_alow (.clk(clk), .rst(rst), .bus(a_if));
  ssd_scan_mux #(.DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0))
    u_two  (.clk(clk), .rst(rst), .bus(t_if));

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int checks = 0;
  int errors = 0;

  // Reference model for the main instance: slot/phase arithmetic on k,
  // the number of clock edges seen since reset release.
  int unsigned k      = 0;
  logic [15:0] mshadow = '0;
  logic [3:0]  mnib    = '0;
  logic        mdark   = 1'b0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;
    logic        lz;
    int unsigned digit;
    logic [6:0]  exp_ssd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [15:0] v;
    logic        ld, lz, r;
    logic [3:0]  mk, ed;
    logic [6:0]  es;
    int unsigned p, d;
    v  = m_if.value;
    ld = m_if.load;
    mk = m_if.blank_mask;
    lz = m_if.lz_suppress;
    r  = rst;
    @(posedge clk);
    #1;
    if (r) begin
      p = k % 8;
      d = (k / 8) % 4;
      if (p < 2) begin
        es = 7'h00;
        ed = 4'b0000;
      end else begin
        es = mdark ? 7'h00 : HEX[mnib];
        ed = 4'b0001 << d;
      end
      chk("model_ssd", {25'd0, m_if.ssd}, {25'd0, es});
      chk("model_dsel", {28'd0, m_if.dsel}, {28'd0, ed});
      chk("model_ssdcat", {31'd0, m_if.ssdcat}, {31'd0, d[0]});
      if (p == 1) begin
        mnib  = 4'(mshadow >> (4 * d));
        mdark = mk[d] | (lz && d != 0 && (mshadow >> (4 * d)) == 16'h0);
      end
      if (ld) mshadow = v;
      k++;
    end
  endtask

  // Advance until the most recent output reflects the given position in
  // the 32-cycle main scan (digit*8 + phase).
  task automatic wait_pos(input int unsigned pos);
    int n = 0;
    while (((k - 1) % 32) != pos && n < 40) begin
      step();
      n++;
    end
    chk("wait_bound", {31'd0, n < 40}, 32'd1);
  endtask

  task automatic load_main(input logic [15:0] v);
    m_if.value = v;
    m_if.load  = 1'b1;
    step();
    m_if.load  = 1'b0;
  endtask

  task automatic addv(input logic [15:0] v, input logic [3:0] mk, input logic lz,
                      input int unsigned dg, input logic [6:0] es);
    vec_t e;
    e.value = v; e.mask = mk; e.lz = lz; e.digit = dg; e.exp_ssd = es;
    vecs.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ph, d, p;
    logic [15:0] rv;
    logic [6:0]  es;
    logic [3:0]  ed;

    addv(16'h12A0, 4'h0, 1'b0, 0, 7'h3F); addv(16'h12A0, 4'h0, 1'b0, 1, 7'h77);
    addv(16'h12A0, 4'h0, 1'b0, 2, 7'h5B); addv(16'h12A0, 4'h0, 1'b0, 3, 7'h06);
    addv(16'h7654, 4'h0, 1'b0, 0, 7'h66); addv(16'h7654, 4'h0, 1'b0, 1, 7'h6D);
    addv(16'h7654, 4'h0, 1'b0, 2, 7'h7D); addv(16'h7654, 4'h0, 1'b0, 3, 7'h07);
    addv(16'hBA98, 4'h0, 1'b0, 0, 7'h7F); addv(16'hBA98, 4'h0, 1'b0, 1, 7'h6F);
    addv(16'hBA98, 4'h0, 1'b0, 2, 7'h77); addv(16'hBA98, 4'h0, 1'b0, 3, 7'h7C);
    addv(16'hFEDC, 4'h0, 1'b0, 0, 7'h39); addv(16'hFEDC, 4'h0, 1'b0, 1, 7'h5E);
    addv(16'hFEDC, 4'h0, 1'b0, 2, 7'h79); addv(16'hFEDC, 4'h0, 1'b0, 3, 7'h71);
    addv(16'h3210, 4'h0, 1'b0, 3, 7'h4F);
    addv(16'h0050, 4'h0, 1'b1, 3, 7'h00); addv(16'h0050, 4'h0, 1'b1, 2, 7'h00);
    addv(16'h0050, 4'h0, 1'b1, 1, 7'h6D); addv(16'h0050, 4'h0, 1'b1, 0, 7'h3F);
    addv(16'h0000, 4'h0, 1'b1, 0, 7'h3F); addv(16'h0000, 4'h0, 1'b1, 1, 7'h00);
    addv(16'h0000, 4'h0, 1'b1, 3, 7'h00);
    addv(16'h0500, 4'h0, 1'b1, 1, 7'h3F); addv(16'h0500, 4'h0, 1'b1, 0, 7'h3F);
    addv(16'h0000, 4'h0, 1'b0, 3, 7'h3F);
    addv(16'h8888, 4'h4, 1'b0, 2, 7'h00); addv(16'h8888, 4'h4, 1'b0, 1, 7'h7F);
    addv(16'h0001, 4'h1, 1'b1, 0, 7'h00); addv(16'h0001, 4'h1, 1'b1, 1, 7'h00);

    m_if.value = '0; m_if.load = 1'b0; m_if.blank_mask = '0; m_if.lz_suppress = 1'b0;
    a_if.value = '0; a_if.load = 1'b0; a_if.blank_mask = '0; a_if.lz_suppress = 1'b0;
    t_if.value = '0; t_if.load = 1'b0; t_if.blank_mask = '0; t_if.lz_suppress = 1'b0;

    // Reset state
    step();
    chk("rst_ssd", {25'd0, m_if.ssd}, 32'h00);
    chk("rst_dsel", {28'd0, m_if.dsel}, 32'h0);
    chk("rst_ssdcat", {31'd0, m_if.ssdcat}, 32'h0);
    chk("rst_alow_ssd", {25'd0, a_if.ssd}, 32'h7F);
    chk("rst_two_dsel", {30'd0, t_if.dsel}, 32'h0);
    rst = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      m_if.blank_mask  = vecs[i].mask;
      m_if.lz_suppress = vecs[i].lz;
      load_main(vecs[i].value);
      repeat (32) step();
      wait_pos(vecs[i].digit * 8 + 4);
      chk("vec_ssd", {25'd0, m_if.ssd}, {25'd0, vecs[i].exp_ssd});
      chk("vec_dsel", {28'd0, m_if.dsel}, 32'd1 << vecs[i].digit);
    end
    m_if.blank_mask  = '0;
    m_if.lz_suppress = 1'b0;

    // Tear-free load in the middle of digit 1's SHOW
    load_main(16'h0000);
    repeat (32) step();
    wait_pos(8 + 3);
    load_main(16'hFFFF);
    chk("tear_hold", {25'd0, m_if.ssd}, 32'h3F);
    repeat (3) begin
      step();
      chk("tear_hold", {25'd0, m_if.ssd}, 32'h3F);
    end
    wait_pos(16 + 2);
    chk("tear_next", {25'd0, m_if.ssd}, 32'h71);

    // Load in the same cycle as SHOW entry for digit 2
    load_main(16'h0000);
    repeat (32) step();
    wait_pos(16);
    load_main(16'hFFFF);
    wait_pos(16 + 3);
    chk("entry_load_old", {25'd0, m_if.ssd}, 32'h3F);
    wait_pos(24 + 3);
    chk("entry_load_new", {25'd0, m_if.ssd}, 32'h71);

    // Asynchronous reset mid-SHOW, then release
    wait_pos(8 + 4);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ssd", {25'd0, m_if.ssd}, 32'h00);
    chk("arst_dsel", {28'd0, m_if.dsel}, 32'h0);
    chk("arst_ssdcat", {31'd0, m_if.ssdcat}, 32'h0);
    chk("arst_alow_ssd", {25'd0, a_if.ssd}, 32'h7F);
    k = 0; mshadow = '0; mnib = '0; mdark = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rel_blank1", {28'd0, m_if.dsel}, 32'h0);
    step();
    chk("rel_blank2", {28'd0, m_if.dsel}, 32'h0);
    step();
    chk("rel_show_dsel", {28'd0, m_if.dsel}, 32'h1);
    chk("rel_show_ssd", {25'd0, m_if.ssd}, 32'h3F);

    // Active-low polarity with digit 1 masked
    a_if.value = 16'h8888; a_if.blank_mask = 4'b0010; a_if.load = 1'b1;
    step();
    a_if.load = 1'b0;
    repeat (32) step();
    repeat (32) begin
      step();
      ph = (k - 1) % 32; d = ph / 8; p = ph % 8;
      es = (p < 2 || d == 1) ? 7'h7F : 7'h00;
      ed = (p < 2) ? 4'b0000 : (4'b0001 << d);
      chk("alow_ssd", {25'd0, a_if.ssd}, {25'd0, es});
      chk("alow_dsel", {28'd0, a_if.dsel}, {28'd0, ed});
    end

    // Two-digit instance: 4-cycle slots, 1 blank cycle
    t_if.value = 8'h21; t_if.load = 1'b1;
    step();
    t_if.load = 1'b0;
    repeat (8) step();
    repeat (16) begin
      step();
      d = ((k - 1) / 4) % 2; p = (k - 1) % 4;
      chk("two_ssdcat", {31'd0, t_if.ssdcat}, {31'd0, d[0]});
      chk("two_dsel", {30'd0, t_if.dsel}, (p == 0) ? 32'd0 : (32'd1 << d));
      chk("two_ssd", {25'd0, t_if.ssd}, (p == 0) ? 32'h00 : ((d == 0) ? 32'h06 : 32'h5B));
    end

    // Random stimulus against the reference model
    repeat (600) begin
      rv = 16'($urandom);
      for (int j = 0; j < 4; j++) if ($urandom_range(1, 0) == 0) rv[4*j +: 4] = 4'h0;
      m_if.value       = rv;
      m_if.load        = ($urandom_range(5, 0) == 0);
      m_if.blank_mask  = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0;
      m_if.lz_suppress = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
- Parametrised N-digit multiplexed 7-segment display driver.
- Supersedes the fixed two-digit cathode-toggle scheme with the following features:
  - configurable digit count
  - programmable refresh rate
  - anti-ghosting blank interval between digits
  - tear-free value loading
  - per-digit blanking
  - leading-zero suppression
- Sits between any value producer (e.g. the Gray counter system) and the board display pins.

Parameters:
- DIGITS, 2, number of multiplexed digits (1..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (blank plus show).
- BLANK_CYCLES, 1000, cycles at the start of each slot with segments forced off. Must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV; violation is an elaboration error.
- SEG_ACTIVE_LOW, 0, 1 inverts ssd polarity at the output register.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is least significant.
- load  in  1  single-cycle strobe; captures value into the shadow register.
- blank_mask  in  DIGITS  bit i=1 forces digit i dark. Sampled at SHOW entry.
- lz_suppress  in  1  enable leading-zero suppression. Sampled at SHOW entry.
- ssd  out  7  segments {g,f,e,d,c,b,a}, registered.
- dsel  out  DIGITS  one-hot active-high digit enable, registered.
- ssdcat  out  1  scan index bit 0, registered, for the two-digit Pmod cathode line.

Behaviour:
- Reset, asynchronous, rst=0:
  - shadow = 0, scan index = 0, prescaler = 0, state = BLANK.
  - ssd = all segments off (7'h00, or 7'h7F if SEG_ACTIVE_LOW).
  - dsel = 0, ssdcat = 0.
- Reset release: the first BLANK interval starts on the first clk edge with rst=1.
- Shadow register:
  - On a clk edge with load=1, shadow <= value; otherwise it holds.
  - The displayed nibble is copied from shadow only at SHOW entry, so a digit never changes mid-slot.
  - load asserted in the same cycle as SHOW entry: the new value is not used for that slot. It appears from the next slot.
- FSM states, with prescaler counting 0..REFRESH_DIV-1 per slot:
  - BLANK (prescaler 0..BLANK_CYCLES-1):
    - ssd = off, dsel = 0.
    - ssdcat = current index bit 0.
    - Moves to SHOW when prescaler = BLANK_CYCLES-1.
  - SHOW (prescaler BLANK_CYCLES..REFRESH_DIV-1):
    - ssd = decoded digit, dsel = one-hot of index.
    - On the prescaler terminal count: prescaler <= 0, index advances (wraps DIGITS-1 -> 0), state -> BLANK.
- Output latency: ssd/dsel are registered, so they reflect the state one cycle after the state register changes.
- Full scan period: DIGITS*REFRESH_DIV cycles.
- Digit dark rule, evaluated at SHOW entry. The digit is dark (ssd = off) when either condition holds:
  - blank_mask[i] = 1, or
  - lz_suppress = 1, i != 0, and shadow nibbles i..DIGITS-1 are all zero.
- Dark-digit outputs: dsel remains asserted, and digit 0 is never suppressed.
- Decode (active-high {g..a}):
  - 0: 3F, 1: 06, 2: 5B, 3: 4F, 4: 66, 5: 6D, 6: 7D, 7: 07
  - 8: 7F, 9: 6F, A: 77, b: 7C, C: 39, d: 5E, E: 79, F: 71
- DIGITS=1: index is constant 0 and ssdcat is constant 0. BLANK/SHOW alternation still occurs.
- Counter widths: prescaler is clog2(REFRESH_DIV) bits; index is max(1, clog2(DIGITS)) bits. No overflow is possible.

Decomposition:
- Package ssd_pkg holds:
  - the 16-entry hex-to-segment constant table
  - the segment bit-order constants
  - the state enum {BLANK, SHOW}.
- One sub-module: ssd_hex_decoder.
  - Combinational nibble -> 7 segments, table lookup plus dark override.
  - Instantiated once and fed by the captured nibble.

Test Plan (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0 unless stated):
- Reset and release: rst=0 mid-SHOW -> ssd=00, dsel=0000, ssdcat=0 immediately (async). After release: 2 cycles blank, then dsel=0001.
- Scan order: load value=16'h12A0 -> slots show dsel 0001/ssd 3F, 0010/77, 0100/5B, 1000/06, then wrap. Each slot is 2 blank cycles plus 6 show cycles; the period is 32 cycles.
- Tear-free load: value=16'h0000 displayed; load 16'hFFFF during digit 1 SHOW -> digit 1 keeps ssd 3F until slot end. The next slot (digit 2) shows 71.
- Leading zeros: value=16'h0050, lz_suppress=1 -> digits 3 and 2 dark with dsel still one-hot. Digit 1 = 6D, digit 0 = 3F. Value 16'h0000 -> only digit 0 lit (3F).
- Blank mask plus polarity: SEG_ACTIVE_LOW=1, blank_mask=0010, value=16'h8888 -> digit 1 ssd=7F (off). Other digits show ssd=00 (all on, '8').
- DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1 -> ssdcat toggles every 4 cycles. During the blank cycle, dsel=00 and ssd=00.
